// File: rtl/mem_arbiter.sv
// Two-owner arbiter for the shared data RAM: the CPU owns it by default, and a device is
// granted on a registered decision with bounded wait and bounded burst length.
module mem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cpu_req,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_data,
  input  logic          i_cpu_we,
  output logic [DW-1:0] o_cpu_data,
  output logic          o_cpu_hlt,
  input  logic          i_dev_req,
  input  logic          i_dev_we,
  input  logic [AW-1:0] i_dev_addr,
  input  logic [DW-1:0] i_dev_data,
  output logic          o_dev_gnt,
  output logic [DW-1:0] o_dev_rdata,
  output logic          o_dev_rvalid,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_data
);

  typedef enum logic [0:0] {StCpuOwn, StDevOwn} state_e;

  localparam logic [3:0] WaitLast  = 4'(MAX_WAIT - 1);
  localparam logic [3:0] BurstLast = 4'(BURST_MAX - 1);

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic          dev_beat;
  logic          dev_rd_beat;

  assign dev_beat    = (state_q == StDevOwn) && i_dev_req;
  assign dev_rd_beat = dev_beat && !i_dev_we;

  assign o_cpu_data   = i_mem_data;
  assign o_dev_rdata  = rdata_q;
  assign o_dev_rvalid = rvalid_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    o_mem_addr = i_cpu_addr;
    o_mem_data = i_cpu_data;
    // No stray CPU write may reach the RAM while reset is held.
    o_mem_we   = i_cpu_we && rst_n;
    o_cpu_hlt  = 1'b0;
    o_dev_gnt  = 1'b0;

    unique case (state_q)
      StCpuOwn: begin
        if (!i_dev_req) begin
          wait_cnt_d = 4'd0;
        end else if (!i_cpu_req || (wait_cnt_q == WaitLast)) begin
          state_d    = StDevOwn;
          wait_cnt_d = 4'd0;
          beat_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      StDevOwn: begin
        o_mem_addr = i_dev_addr;
        o_mem_data = i_dev_data;
        o_mem_we   = i_dev_we && i_dev_req;
        o_cpu_hlt  = 1'b1;
        o_dev_gnt  = 1'b1;
        if (!i_dev_req) begin
          state_d    = StCpuOwn;
          beat_cnt_d = 4'd0;
        end else if (beat_cnt_q == BurstLast) begin
          // Burst cap reached: the CPU gets at least one cycle before any re-grant.
          state_d    = StCpuOwn;
          beat_cnt_d = 4'd0;
        end else begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end

      default: state_d = StCpuOwn;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StCpuOwn;
      wait_cnt_q <= 4'd0;
      beat_cnt_q <= 4'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= dev_rd_beat;
      if (dev_rd_beat) begin
        rdata_q <= i_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked every cycle
// against an ownership-level reference model and a shadow copy of the RAM.
module tb_mem_arbiter;

  localparam int unsigned AW        = 8;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned BURST_MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cpu_req, i_cpu_we, i_dev_req, i_dev_we;
  logic [AW-1:0] i_cpu_addr, i_dev_addr;
  logic [DW-1:0] i_cpu_data, i_dev_data;
  logic [DW-1:0] o_cpu_data, o_dev_rdata, o_mem_data, i_mem_data;
  logic          o_cpu_hlt, o_dev_gnt, o_dev_rvalid, o_mem_we;
  logic [AW-1:0] o_mem_addr;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  // Reference model: who owns the RAM, how long the device has waited, beats this grant.
  bit         m_dev_owns;
  int         m_waited;
  int         m_beats;
  bit         m_rvalid;
  logic [7:0] m_rdata;
  bit         last_beat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign i_mem_data = mem[o_mem_addr];

  mem_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .MAX_WAIT  (MAX_WAIT),
    .BURST_MAX (BURST_MAX)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_req    (i_cpu_req),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_data   (i_cpu_data),
    .i_cpu_we     (i_cpu_we),
    .o_cpu_data   (o_cpu_data),
    .o_cpu_hlt    (o_cpu_hlt),
    .i_dev_req    (i_dev_req),
    .i_dev_we     (i_dev_we),
    .i_dev_addr   (i_dev_addr),
    .i_dev_data   (i_dev_data),
    .o_dev_gnt    (o_dev_gnt),
    .o_dev_rdata  (o_dev_rdata),
    .o_dev_rvalid (o_dev_rvalid),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_we     (o_mem_we),
    .i_mem_data   (i_mem_data)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dev_owns = 1'b0;
    m_waited   = 0;
    m_beats    = 0;
    m_rvalid   = 1'b0;
    m_rdata    = 8'h00;
    last_beat  = 1'b0;
  endtask

  // Called just after a falling edge with this cycle's inputs applied; returns at the next one.
  task automatic step();
    logic [7:0] e_addr, e_data, s_addr, s_data;
    logic       e_we, s_we;
    bit         beat;
    #1;
    if (m_dev_owns) begin
      e_addr = i_dev_addr;
      e_data = i_dev_data;
      e_we   = i_dev_we && i_dev_req;
    end else begin
      e_addr = i_cpu_addr;
      e_data = i_cpu_data;
      e_we   = i_cpu_we;
    end
    check("gnt", o_dev_gnt, m_dev_owns);
    check("hlt", o_cpu_hlt, m_dev_owns);
    check("mem_addr", o_mem_addr, e_addr);
    check("mem_data", o_mem_data, e_data);
    check("mem_we", o_mem_we, e_we);
    check("cpu_data", o_cpu_data, ref_mem[e_addr]);
    check("rvalid", o_dev_rvalid, m_rvalid);
    check("rdata", o_dev_rdata, m_rdata);
    s_we   = o_mem_we;
    s_addr = o_mem_addr;
    s_data = o_mem_data;
    @(posedge clk);
    if (s_we) mem[s_addr] <= s_data;
    beat = m_dev_owns && i_dev_req;
    if (beat && !i_dev_we) m_rdata = ref_mem[i_dev_addr];
    m_rvalid = beat && !i_dev_we;
    if (e_we) ref_mem[e_addr] = e_data;
    if (m_dev_owns) begin
      if (beat) m_beats++;
      if (!i_dev_req || m_beats == BURST_MAX) m_dev_owns = 1'b0;
    end else if (i_dev_req) begin
      if (!i_cpu_req || m_waited + 1 == MAX_WAIT) begin
        m_dev_owns = 1'b1;
        m_beats    = 0;
        m_waited   = 0;
      end else begin
        m_waited++;
      end
    end else begin
      m_waited = 0;
    end
    last_beat = beat;
    @(negedge clk);
  endtask

  initial begin
    int n, k, first_run, gap;
    bit seen;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    mem[8'h10]     = 8'hA5;
    ref_mem[8'h10] = 8'hA5;

    rst_n      = 1'b0;
    i_cpu_req  = 1'b0;
    i_cpu_we   = 1'b1;
    i_cpu_addr = 8'h20;
    i_cpu_data = 8'h11;
    i_dev_req  = 1'b0;
    i_dev_we   = 1'b0;
    i_dev_addr = 8'h00;
    i_dev_data = 8'h00;
    model_reset();

    #12;
    check("rst_gnt", o_dev_gnt, 1'b0);
    check("rst_hlt", o_cpu_hlt, 1'b0);
    check("rst_rvalid", o_dev_rvalid, 1'b0);
    check("rst_rdata", o_dev_rdata, 8'h00);
    check("rst_mem_we", o_mem_we, 1'b0);
    check("rst_mem_addr", o_mem_addr, 8'h20);
    @(negedge clk);
    rst_n    = 1'b1;
    i_cpu_we = 1'b0;

    // Idle CPU, device reads 0x10.
    i_dev_req  = 1'b1;
    i_dev_addr = 8'h10;
    step();
    check("idle_gnt", o_dev_gnt, 1'b1);
    step();
    i_dev_req = 1'b0;
    check("idle_rvalid", o_dev_rvalid, 1'b1);
    check("idle_rdata", o_dev_rdata, 8'hA5);
    step();
    step();
    check("idle_release", o_dev_gnt, 1'b0);

    // Busy CPU: device waits MAX_WAIT cycles; CPU store masked while granted.
    i_cpu_req  = 1'b1;
    i_cpu_addr = 8'h21;
    i_dev_req  = 1'b1;
    i_dev_addr = 8'h11;
    n = 0;
    while (!o_dev_gnt && n < 20) begin
      step();
      n++;
    end
    check("starve_lat", n, MAX_WAIT);
    i_cpu_we   = 1'b1;
    i_cpu_addr = 8'h20;
    i_cpu_data = 8'h77;
    #1;
    check("starve_mask", o_mem_we, 1'b0);
    step();
    i_dev_req = 1'b0;
    i_cpu_we  = 1'b0;
    step();
    step();
    check("starve_0x20", mem[8'h20], init_val(32'h20));

    // Burst cap: six writes held back-to-back with an idle CPU.
    i_cpu_req = 1'b0;
    k = 0; n = 0; first_run = 0; gap = 0; seen = 1'b0;
    while (k < 6 && n < 40) begin
      i_dev_req  = 1'b1;
      i_dev_we   = 1'b1;
      i_dev_addr = 8'(8'h30 + k);
      i_dev_data = 8'(k + 1);
      if (o_dev_gnt) begin
        seen = 1'b1;
        if (gap == 0) first_run++;
      end else if (seen) begin
        gap++;
      end
      step();
      n++;
      if (last_beat) k++;
    end
    i_dev_req = 1'b0;
    i_dev_we  = 1'b0;
    step();
    step();
    check("burst_first_run", first_run, BURST_MAX);
    check("burst_gap", gap, 1);
    for (int i = 0; i < 6; i++) check("burst_mem", mem[8'h30 + i], 8'(i + 1));

    // CPU store on the cycle the grant is decided still lands.
    i_cpu_req  = 1'b1;
    i_dev_req  = 1'b1;
    i_dev_addr = 8'h41;
    for (int i = 0; i < int'(MAX_WAIT); i++) begin
      i_cpu_we   = (i == int'(MAX_WAIT) - 1);
      i_cpu_addr = 8'h40;
      i_cpu_data = 8'h55;
      step();
    end
    check("handover_gnt", o_dev_gnt, 1'b1);
    check("handover_mem", mem[8'h40], 8'h55);
    i_cpu_we = 1'b0;
    step();
    i_dev_req = 1'b0;
    step();
    step();

    // Early release after two of four beats.
    i_cpu_req = 1'b0;
    i_dev_we  = 1'b1;
    k = 0; n = 0;
    while (k < 2 && n < 20) begin
      i_dev_req  = 1'b1;
      i_dev_addr = 8'(8'h50 + k);
      i_dev_data = 8'(8'hC0 + k);
      step();
      n++;
      if (last_beat) k++;
    end
    i_dev_req = 1'b0;
    step();
    check("early_hlt", o_cpu_hlt, 1'b0);
    check("early_gnt", o_dev_gnt, 1'b0);

    // Asynchronous reset in the middle of a read burst.
    i_dev_we   = 1'b0;
    i_dev_req  = 1'b1;
    i_dev_addr = 8'h60;
    k = 0; n = 0;
    while (k < 2 && n < 20) begin
      step();
      n++;
      if (last_beat) k++;
    end
    check("midrst_pre_gnt", o_dev_gnt, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gnt", o_dev_gnt, 1'b0);
    check("midrst_hlt", o_cpu_hlt, 1'b0);
    check("midrst_rvalid", o_dev_rvalid, 1'b0);
    check("midrst_mem_we", o_mem_we, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    i_dev_req = 1'b0;
    step();
    check("midrst_after", o_dev_gnt, 1'b0);

    // Random traffic; device obeys the hold-until-granted protocol.
    for (int c = 0; c < 800; c++) begin
      i_cpu_req  = 1'($urandom_range(0, 1));
      i_cpu_we   = i_cpu_req && ($urandom_range(0, 3) == 0);
      i_cpu_addr = 8'($urandom);
      i_cpu_data = 8'($urandom);
      if (!i_dev_req || last_beat) begin
        i_dev_req  = ($urandom_range(0, 2) != 0);
        i_dev_we   = 1'($urandom_range(0, 1));
        i_dev_addr = 8'($urandom);
        i_dev_data = 8'($urandom);
      end
      step();
    end
    i_dev_req = 1'b0;
    i_cpu_we  = 1'b0;
    step();
    step();
    for (int i = 0; i < 256; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
